wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that owns the single write port of the general-purpose register file. It merges results from the single-cycle ALU path (no backpressure) and the load/store unit (valid/ready handshake, buffered in a small FIFO) into one registered `dest_en`/`dest_addr`/`dest_data` stream. It also keeps a pending-load scoreboard so the decode stage can stall on registers whose load result has not yet been written.

## Interface
Parameters:
- `LSU_DEPTH`, default 2: LSU result FIFO entries (power of two, ≥2).
- `REG_COUNT`, default 32: number of GPRs. Address width is `$clog2(REG_COUNT)`, 5 for the default.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result present this cycle; always accepted.
- `alu_addr` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `lsu_valid` in 1: LSU result offered.
- `lsu_ready` out 1: arbiter can accept an LSU result.
- `lsu_addr` in 5: load destination register.
- `lsu_data` in 32: load data.
- `issue_en` in 1: decode issued a load this cycle.
- `issue_addr` in 5: destination register of the issued load.
- `rs1_addr` in 5: scoreboard query address 1.
- `rs1_busy` out 1: `rs1_addr` has a pending load.
- `rs2_addr` in 5: scoreboard query address 2.
- `rs2_busy` out 1: `rs2_addr` has a pending load.
- `dest_en` out 1: register file write enable (registered).
- `dest_addr` out 5: register file write address (registered).
- `dest_data` out 32: register file write data (registered).

## Operation
LSU FIFO:
- `lsu_ready` = FIFO count < `LSU_DEPTH`. It depends only on the registered count, not on a same-cycle pop.
- Handshake completes when `lsu_valid && lsu_ready`.

Source select, evaluated each cycle in priority order:
1. `alu_valid`: the ALU result is selected.
2. FIFO not empty: the FIFO head is selected and popped.
3. FIFO empty and LSU handshake completes: the incoming LSU result is selected directly and is not enqueued.
4. Otherwise nothing is selected.

An LSU handshake not consumed by rule 3 is enqueued. Enqueue and pop may occur in the same cycle, and the count is then unchanged.

Register x0:
- A selected result with address 0 is consumed normally (pop, handshake complete).
- It produces `dest_en=0` on the next cycle.

Output register:
- On the next edge, `dest_en`/`dest_addr`/`dest_data` take the selected result.
- With no selection, `dest_en=0` and `dest_addr`/`dest_data` hold their previous values.

Scoreboard (`pending[REG_COUNT-1:1]`):
- `issue_en` with `issue_addr≠0` sets `pending[issue_addr]`.
- A selected LSU result (from FIFO or direct) clears `pending[lsu addr]` on the same edge that registers it to `dest_*`.
- A set and a clear to the same address in the same cycle: set wins, because a newer load has been issued.
- ALU writes never touch `pending`.
- `rsN_busy` = `pending[rsN_addr]` combinationally. Address 0 always reads 0.

Reset values:
- `dest_en=0`, `dest_addr=0`, `dest_data=0`.
- FIFO empty, so `lsu_ready=1` after reset.
- All `pending` bits 0.
- Reset asserted mid-operation discards FIFO contents and scoreboard state immediately, regardless of the clock.

## Timing
- ALU latency: result at cycle N produces `dest_en=1` at cycle N+1.
- LSU latency: 1 cycle when the FIFO is empty and ALU is idle; otherwise it waits behind ALU traffic and older FIFO entries.
- Ordering:
  - LSU results are written in handshake order.
  - ALU results are written in arrival order.
  - No ordering is guaranteed between the ALU and LSU streams. Decode prevents WAW through the scoreboard.
- A scoreboard clear becomes visible on `rsN_busy` in the same cycle `dest_en` presents the value. The register file's write bypass supplies the data in that cycle.
- Full FIFO: `lsu_ready=0` until the cycle after a pop.
- Sustained `alu_valid` starves the LSU. The FIFO fills and backpressures the LSU; no data is lost.

## Test plan
- Reset release:
  - After `rst_n` deasserts: `dest_en=0`, `lsu_ready=1`, `rs1_busy=rs2_busy=0`.
  - ALU valid, addr 5, data 0x1234 at cycle N → cycle N+1: `dest_en=1`, `dest_addr=5`, `dest_data=0x1234`.
- Load bypass path:
  - Issue load to x7 → `rs1_busy(7)=1`.
  - LSU valid, addr 7, data 0xDEAD with ALU idle → next cycle writes x7=0xDEAD and `rs1_busy` drops to 0 in that cycle.
- Contention and backpressure:
  - Hold ALU valid for 4 cycles while the LSU offers 3 results (x1, x2, x3).
  - `lsu_ready` deasserts after two are accepted.
  - After the ALU stops: x1, x2, x3 are written in order on consecutive cycles.
- x0 handling:
  - ALU write to x0 → `dest_en` stays 0.
  - LSU result to x0 completes its handshake and produces no write.
  - Issue to x0 never raises busy.
- Scoreboard collision:
  - In the cycle the x9 load result is selected, `issue_en` to x9 fires.
  - Required: `pending[9]` remains 1 afterward and `dest_*` writes the old result.
- Async reset mid-run: assert `rst_n` low with a FIFO holding 2 entries and pending x4 → immediately `dest_en=0`, FIFO empty, busy bits clear.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU and LSU results with pending-load scoreboard
module wb_arbiter #(
    parameter int LSU_DEPTH = 2,
    parameter int REG_COUNT = 32,
    localparam int AW = $clog2(REG_COUNT),
    localparam int PW = $clog2(LSU_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [31:0]   alu_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic [31:0]   lsu_data,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_addr,
    input  logic [AW-1:0] rs1_addr,
    output logic          rs1_busy,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs2_busy,
    output logic          dest_en,
    output logic [AW-1:0] dest_addr,
    output logic [31:0]   dest_data
);

    logic [AW-1:0]        r_fifo_addr [LSU_DEPTH];
    logic [31:0]          r_fifo_data [LSU_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW:0]          r_count;
    logic [REG_COUNT-1:0] r_pending;
    logic                 r_dest_en;
    logic [AW-1:0]        r_dest_addr;
    logic [31:0]          r_dest_data;

    logic                 w_empty;
    logic                 w_hs;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_sel_valid;
    logic                 w_sel_lsu;
    logic [AW-1:0]        w_sel_addr;
    logic [31:0]          w_sel_data;

    // Ready only looks at the registered count so a full FIFO stays closed until after a pop
    assign w_empty   = (r_count == '0);
    assign lsu_ready = (r_count < (PW+1)'(LSU_DEPTH));
    assign w_hs      = lsu_valid && lsu_ready;

    // Priority select: ALU, then FIFO head, then a direct LSU bypass when the FIFO is empty
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_lsu   = 1'b0;
        w_sel_addr  = alu_addr;
        w_sel_data  = alu_data;
        w_pop       = 1'b0;
        w_push      = w_hs;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
        end else if (!w_empty) begin
            w_sel_valid = 1'b1;
            w_sel_lsu   = 1'b1;
            w_pop       = 1'b1;
            w_sel_addr  = r_fifo_addr[r_rd_ptr];
            w_sel_data  = r_fifo_data[r_rd_ptr];
        end else if (w_hs) begin
            w_sel_valid = 1'b1;
            w_sel_lsu   = 1'b1;
            w_push      = 1'b0;
            w_sel_addr  = lsu_addr;
            w_sel_data  = lsu_data;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= lsu_addr;
            r_fifo_data[r_wr_ptr] <= lsu_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered write port; x0 results are consumed but never enable a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dest_en   <= 1'b0;
            r_dest_addr <= '0;
            r_dest_data <= '0;
        end else if (w_sel_valid) begin
            r_dest_en   <= (w_sel_addr != '0);
            r_dest_addr <= w_sel_addr;
            r_dest_data <= w_sel_data;
        end else begin
            r_dest_en   <= 1'b0;
        end
    end

    // Pending-load scoreboard: clear on LSU writeback, then a same-cycle issue re-sets the bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            if (w_sel_lsu && (w_sel_addr != '0))
                r_pending[w_sel_addr] <= 1'b0;
            if (issue_en && (issue_addr != '0))
                r_pending[issue_addr] <= 1'b1;
        end
    end

    assign rs1_busy  = (rs1_addr != '0) && r_pending[rs1_addr];
    assign rs2_busy  = (rs2_addr != '0) && r_pending[rs2_addr];
    assign dest_en   = r_dest_en;
    assign dest_addr = r_dest_addr;
    assign dest_data = r_dest_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic [4:0]  rs1_addr;
    logic        rs1_busy;
    logic [4:0]  rs2_addr;
    logic        rs2_busy;
    logic        dest_en;
    logic [4:0]  dest_addr;
    logic [31:0] dest_data;

    int checks = 0;
    int errors = 0;

    wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .rs1_addr   (rs1_addr),
        .rs1_busy   (rs1_busy),
        .rs2_addr   (rs2_addr),
        .rs2_busy   (rs2_busy),
        .dest_en    (dest_en),
        .dest_addr  (dest_addr),
        .dest_data  (dest_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_dest(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".en"}, 32'(dest_en), 32'(en));
        if (en) begin
            chk({tag, ".addr"}, 32'(dest_addr), 32'(a));
            chk({tag, ".data"}, dest_data, d);
        end
    endtask

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
        issue_en = 1'b0; issue_addr = '0; rs1_addr = '0; rs2_addr = '0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst.dest_en", 32'(dest_en), 32'd0);
        chk("rst.dest_addr", 32'(dest_addr), 32'd0);
        chk("rst.dest_data", dest_data, 32'd0);
        chk("rst.lsu_ready", 32'(lsu_ready), 32'd1);
        rs1_addr = 5'd3; rs2_addr = 5'd17;
        chk("rst.rs1_busy", 32'(rs1_busy), 32'd0);
        chk("rst.rs2_busy", 32'(rs2_busy), 32'd0);

        // ALU one-cycle latency
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
        tick();
        alu_valid = 1'b0;
        chk_dest("alu5", 1'b1, 5'd5, 32'h1234);

        // Load bypass path
        issue_en = 1'b1; issue_addr = 5'd7; rs1_addr = 5'd7;
        tick();
        issue_en = 1'b0;
        chk("ld7.busy_set", 32'(rs1_busy), 32'd1);
        chk("ld7.idle_dest", 32'(dest_en), 32'd0);
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hDEAD;
        chk("ld7.ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk_dest("ld7.write", 1'b1, 5'd7, 32'hDEAD);
        chk("ld7.busy_clr", 32'(rs1_busy), 32'd0);

        // Contention: ALU busy 4 cycles, LSU offers x1, x2, x3
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_addr = 5'(10 + k); alu_data = 32'hA0 + 32'(k);
            lsu_valid = 1'b1;
            lsu_addr  = (k < 2) ? 5'(k + 1) : 5'd3;
            lsu_data  = (k == 0) ? 32'h11 : (k == 1) ? 32'h22 : 32'h33;
            chk($sformatf("cont.ready%0d", k), 32'(lsu_ready), (k < 2) ? 32'd1 : 32'd0);
            tick();
            chk_dest($sformatf("cont.alu%0d", k), 1'b1, 5'(10 + k), 32'hA0 + 32'(k));
        end
        alu_valid = 1'b0;
        chk("cont.ready4", 32'(lsu_ready), 32'd0);
        tick();
        chk_dest("cont.x1", 1'b1, 5'd1, 32'h11);
        chk("cont.ready5", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk_dest("cont.x2", 1'b1, 5'd2, 32'h22);
        tick();
        chk_dest("cont.x3", 1'b1, 5'd3, 32'h33);
        tick();
        chk("cont.drained", 32'(dest_en), 32'd0);
        chk("cont.ready_end", 32'(lsu_ready), 32'd1);

        // x0 handling
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
        tick();
        alu_valid = 1'b0;
        chk("x0.alu", 32'(dest_en), 32'd0);
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h66;
        chk("x0.lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk("x0.lsu", 32'(dest_en), 32'd0);
        chk("x0.fifo_empty", 32'(lsu_ready), 32'd1);
        issue_en = 1'b1; issue_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        issue_en = 1'b0;
        chk("x0.busy", 32'(rs2_busy), 32'd0);
        chk("x0.no_write", 32'(dest_en), 32'd0);

        // Scoreboard collision: set wins over clear
        issue_en = 1'b1; issue_addr = 5'd9; rs2_addr = 5'd9;
        tick();
        chk("col.busy_set", 32'(rs2_busy), 32'd1);
        lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'hBEEF;
        tick();
        issue_en = 1'b0; lsu_valid = 1'b0;
        chk_dest("col.write", 1'b1, 5'd9, 32'hBEEF);
        chk("col.busy_kept", 32'(rs2_busy), 32'd1);
        lsu_valid = 1'b1; lsu_data = 32'hC0DE;
        tick();
        lsu_valid = 1'b0;
        chk_dest("col.write2", 1'b1, 5'd9, 32'hC0DE);
        chk("col.busy_clr", 32'(rs2_busy), 32'd0);

        // Async reset mid-run with two FIFO entries and pending x4
        issue_en = 1'b1; issue_addr = 5'd4; rs1_addr = 5'd4;
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'h77;
        lsu_valid = 1'b1; lsu_addr = 5'd20; lsu_data = 32'h200;
        tick();
        issue_en = 1'b0;
        lsu_addr = 5'd21; lsu_data = 32'h210;
        tick();
        lsu_valid = 1'b0;
        chk("ar.full", 32'(lsu_ready), 32'd0);
        chk("ar.busy4", 32'(rs1_busy), 32'd1);
        chk("ar.dest_before", 32'(dest_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.dest_en", 32'(dest_en), 32'd0);
        chk("ar.ready", 32'(lsu_ready), 32'd1);
        chk("ar.busy_clr", 32'(rs1_busy), 32'd0);
        alu_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar.fifo_discarded", 32'(dest_en), 32'd0);
        chk("ar.ready_after", 32'(lsu_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
